// File: rtl/lcd_hex_writer.sv
// lcd_hex_writer: shows each 16-bit display word sampled on a syscall as four
// ASCII hex characters on an HD44780-style 8-bit character LCD bus.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   call       in   syscall strobe (level); one push per rising edge
//   data       in   16-bit display word, sampled on the call rising edge
//   lcd_rs     out  register select, 1 = data write
//   lcd_rw     out  read/write, always 0 (write)
//   lcd_e      out  enable strobe
//   lcd_db     out  character bus
//   busy       out  FSM not idle or FIFO non-empty
//   fifo_count out  FIFO occupancy
//   overflow   out  sticky, a word was dropped because the FIFO was full
//
// Parameters: DEPTH (power of 2, >= 2), SETUP_CYC, E_CYC, HOLD_CYC (>= 1).
// Macro LCD_HEX_SEPARATOR_EN: append a space after every word's four digits.
module lcd_hex_writer #(
   parameter int DEPTH     = 4,
   parameter int SETUP_CYC = 2,
   parameter int E_CYC     = 4,
   parameter int HOLD_CYC  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   call,
   input  logic [15:0]            data,
   output logic                   lcd_rs,
   output logic                   lcd_rw,
   output logic                   lcd_e,
   output logic [7:0]             lcd_db,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(SETUP_CYC + E_CYC + HOLD_CYC + 1);
`ifdef LCD_HEX_SEPARATOR_EN
   localparam int IW = 3;
   localparam logic [IW-1:0] LAST = IW'(4);
`else
   localparam int IW = 2;
   localparam logic [IW-1:0] LAST = IW'(3);
`endif

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, NEXT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   wr_q, rd_q;
   logic [AW:0]     count_q, count_d;
   logic [15:0]     mem [DEPTH];
   logic            call_q, ovf_q, e_q;
   logic [7:0]      db_q;
   logic            push, pop, full, push_ok;
   logic [15:0]     head;
   logic [3:0]      nib;
   logic [7:0]      chr;

   assign push    = call & ~call_q;
   assign pop     = (state_q == NEXT) && (idx_q == LAST);
   assign full    = count_q == (AW+1)'(DEPTH);
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign push_ok = push & (~full | pop);
   assign count_d = (push_ok & ~pop) ? count_q + (AW+1)'(1) :
                    (pop & ~push_ok) ? count_q - (AW+1)'(1) : count_q;

   // The head entry is read in place; writes only ever target a free slot.
   assign head = mem[rd_q];
   assign nib  = (idx_q == IW'(0)) ? head[15:12] :
                 (idx_q == IW'(1)) ? head[11:8]  :
                 (idx_q == IW'(2)) ? head[7:4]   : head[3:0];
`ifdef LCD_HEX_SEPARATOR_EN
   assign chr  = (idx_q == LAST) ? 8'h20 :
                 (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
`else
   assign chr  = (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE:    state_d = (count_q != '0) ? SETUP : IDLE;
         SETUP:   state_d = (cnt_q == CW'(SETUP_CYC - 1)) ? PULSE : SETUP;
         PULSE:   state_d = (cnt_q == CW'(E_CYC - 1)) ? HOLD : PULSE;
         HOLD:    state_d = (cnt_q == CW'(HOLD_CYC - 1)) ? NEXT : HOLD;
         NEXT: begin
            idx_d   = (idx_q == LAST) ? '0 : idx_q + IW'(1);
            // count_d already includes this cycle's pop and any concurrent push.
            state_d = (idx_q != LAST || count_d != '0) ? SETUP : IDLE;
         end
         default: state_d = IDLE;
      endcase
      cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + CW'(1);
   end

   // Idle with nothing queued: the bus keeps its last character.
   assign lcd_db     = (state_q == IDLE && count_q == '0) ? db_q : chr;
   assign busy       = (state_q != IDLE) || (count_q != '0);
   assign lcd_rs     = busy;
   assign lcd_rw     = 1'b0;
   assign lcd_e      = e_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         call_q  <= 1'b0;
         ovf_q   <= 1'b0;
         e_q     <= 1'b0;
         db_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= push_ok ? wr_q + AW'(1) : wr_q;
         rd_q    <= pop ? rd_q + AW'(1) : rd_q;
         count_q <= count_d;
         call_q  <= call;
         ovf_q   <= ovf_q | (push & full & ~pop);
         // Registered so the enable strobe is glitch-free on the pin.
         e_q     <= state_d == PULSE;
         db_q    <= lcd_db;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_q] <= data;
   end
endmodule
